// File: rtl/nes_joypad_pkg.sv
// Shared types and constants for the NES joypad port.
// Mode encoding, button bit positions, signatures and the Power Pad mapping.
package nes_joypad_pkg;

    typedef enum logic [1:0] {
        JP_STD       = 2'd0,
        JP_FOURSCORE = 2'd1,
        JP_POWERPAD  = 2'd2
    } jp_mode_e;

    localparam int BTN_A      = 0;
    localparam int BTN_B      = 1;
    localparam int BTN_SELECT = 2;
    localparam int BTN_START  = 3;
    localparam int BTN_UP     = 4;
    localparam int BTN_DOWN   = 5;
    localparam int BTN_LEFT   = 6;
    localparam int BTN_RIGHT  = 7;

    localparam logic [7:0] DEF_SIG_P1 = 8'h10;
    localparam logic [7:0] DEF_SIG_P2 = 8'h20;

    // Returns {d4_nibble[3:0], d3_byte[7:0]} in the order the pad serialises.
    function automatic logic [11:0] pp_map(input logic [11:0] pp);
        return {pp[7], pp[11], pp[2], pp[3],
                pp[6], pp[10], pp[9], pp[5],
                pp[8], pp[4],  pp[0], pp[1]};
    endfunction

endpackage

// File: rtl/nes_joypad_shifter.sv
// Generic load/shift-right register with a serial fill input.
// Load has priority over shift; only the LSB is exposed.
module nes_joypad_shifter
    import nes_joypad_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             load,
    input  logic             shift,
    input  logic             fill,
    input  logic [WIDTH-1:0] load_val,
    output logic             q0
);

    logic [WIDTH-1:0] q;

    // Shift register: clear, parallel load, or shift right with fill.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            q <= '0;
        end else if (load) begin
            q <= load_val;
        end else if (shift) begin
            q <= {fill, q[WIDTH-1:1]};
        end
    end

    assign q0 = q[0];

endmodule

// File: rtl/nes_joypad_port.sv
// NES $4016/$4017 joypad port: standard pads, Four Score and Power Pad.
// Optional turbo A/B support is built when JOYPAD_TURBO_EN is defined.
module nes_joypad_port
    import nes_joypad_pkg::*;
#(
    parameter int         NUM_PADS = 4,
    parameter logic       FILL_BIT = 1'b1,
    parameter logic [7:0] SIG_P1   = DEF_SIG_P1,
    parameter logic [7:0] SIG_P2   = DEF_SIG_P2
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [1:0]            mode,
    input  logic [NUM_PADS*8-1:0] pads,
`ifdef JOYPAD_TURBO_EN
    input  logic [NUM_PADS*2-1:0] turbo,
`endif
    input  logic [11:0]           powerpad,
    input  logic                  joypad_strobe,
    input  logic [1:0]            joypad_clock,
    output logic [3:0]            joypad_data
);

    logic [7:0]  pad [4];
    logic [1:0]  last_clk;
    logic [1:0]  mode_q;
    logic [1:0]  fall;
    logic        pd_fill;
    logic [11:0] pp_bits;
    logic [23:0] sr1_ld;
    logic [23:0] sr2_ld;
    logic [7:0]  pd3_ld;
    logic [7:0]  pd4_ld;
    logic        sr1_q0;
    logic        sr2_q0;
    logic        pd3_q0;
    logic        pd4_q0;

`ifdef JOYPAD_TURBO_EN
    localparam int TURBO_DIV = 4;

    logic       strobe_q;
    logic [7:0] turbo_cnt;
    logic [7:0] turbo_cnt_nx;
    logic       turbo_phase;

    assign turbo_cnt_nx = turbo_cnt + 8'd1;

    // Count strobe rising edges (frames) and flip the turbo phase.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            strobe_q    <= 1'b0;
            turbo_cnt   <= 8'd0;
            turbo_phase <= 1'b0;
        end else begin
            strobe_q <= joypad_strobe;
            if (joypad_strobe && !strobe_q) begin
                turbo_cnt <= turbo_cnt_nx;
                if ((32'(turbo_cnt_nx) % TURBO_DIV) == 0) begin
                    turbo_phase <= ~turbo_phase;
                end
            end
        end
    end
`endif

    genvar gi;
    for (gi = 0; gi < 4; gi++) begin : g_pad
        if (gi < NUM_PADS) begin : g_on
`ifdef JOYPAD_TURBO_EN
            logic [7:0] tmask;
            always_comb begin
                tmask = 8'h00;
                tmask[BTN_A] = turbo[gi*2]   & turbo_phase;
                tmask[BTN_B] = turbo[gi*2+1] & turbo_phase;
            end
            assign pad[gi] = pads[gi*8 +: 8] | tmask;
`else
            assign pad[gi] = pads[gi*8 +: 8];
`endif
        end else begin : g_off
            assign pad[gi] = 8'h00;
        end
    end

    assign pp_bits = pp_map(powerpad);

    // Load images for each shift register, chosen from the live mode input.
    always_comb begin
        sr1_ld = {{16{FILL_BIT}}, pad[0]};
        sr2_ld = {{16{FILL_BIT}}, pad[1]};
        pd3_ld = 8'h00;
        pd4_ld = 8'h00;
        case (mode)
            JP_FOURSCORE: begin
                sr1_ld = {SIG_P1, pad[2], pad[0]};
                sr2_ld = {SIG_P2, pad[3], pad[1]};
            end
            JP_POWERPAD: begin
                pd3_ld = pp_bits[7:0];
                pd4_ld = {{4{FILL_BIT}}, pp_bits[11:8]};
            end
            default: ;
        endcase
    end

    // Clock edge history and the mode latched at the last strobe.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            last_clk <= 2'b00;
            mode_q   <= 2'b00;
        end else begin
            last_clk <= joypad_clock;
            if (joypad_strobe) begin
                mode_q <= mode;
            end
        end
    end

    assign fall    = last_clk & ~joypad_clock;
    assign pd_fill = (mode_q == JP_POWERPAD) ? FILL_BIT : 1'b0;

    nes_joypad_shifter #(.WIDTH(24)) u_sr1 (
        .clk      (clk),
        .reset_n  (reset_n),
        .load     (joypad_strobe),
        .shift    (fall[0]),
        .fill     (FILL_BIT),
        .load_val (sr1_ld),
        .q0       (sr1_q0)
    );

    nes_joypad_shifter #(.WIDTH(24)) u_sr2 (
        .clk      (clk),
        .reset_n  (reset_n),
        .load     (joypad_strobe),
        .shift    (fall[1]),
        .fill     (FILL_BIT),
        .load_val (sr2_ld),
        .q0       (sr2_q0)
    );

    nes_joypad_shifter #(.WIDTH(8)) u_pd3 (
        .clk      (clk),
        .reset_n  (reset_n),
        .load     (joypad_strobe),
        .shift    (fall[1]),
        .fill     (pd_fill),
        .load_val (pd3_ld),
        .q0       (pd3_q0)
    );

    nes_joypad_shifter #(.WIDTH(8)) u_pd4 (
        .clk      (clk),
        .reset_n  (reset_n),
        .load     (joypad_strobe),
        .shift    (fall[1]),
        .fill     (pd_fill),
        .load_val (pd4_ld),
        .q0       (pd4_q0)
    );

    assign joypad_data = {pd4_q0, pd3_q0, sr2_q0, sr1_q0};

endmodule

// File: tb/tb_nes_joypad_port.sv
// Directed, table-driven bench for nes_joypad_port.
// Turbo sequence is exercised when JOYPAD_TURBO_EN is defined.
module tb_nes_joypad_port;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [1:0]  mode;
    logic [31:0] pads;
    logic [11:0] powerpad;
    logic        strobe;
    logic [1:0]  jclk;
    logic [3:0]  data;
`ifdef JOYPAD_TURBO_EN
    logic [7:0]  turbo;
`endif

    int checks = 0;
    int errors = 0;

    nes_joypad_port dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .mode          (mode),
        .pads          (pads),
`ifdef JOYPAD_TURBO_EN
        .turbo         (turbo),
`endif
        .powerpad      (powerpad),
        .joypad_strobe (strobe),
        .joypad_clock  (jclk),
        .joypad_data   (data)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic [1:0]  mode;
        logic [31:0] pads;
        logic [11:0] pp;
        int          lane;
        int          n;
        logic [31:0] exp;
        string       name;
    } vec_t;

    vec_t vecs[12];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(string name, logic [3:0] act, logic [3:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic load();
        strobe = 1'b1;
        tick();
        strobe = 1'b0;
        tick();
    endtask

    task automatic pulse(int port);
        jclk[port] = 1'b1;
        tick();
        jclk[port] = 1'b0;
        tick();
    endtask

    task automatic reads(int lane, int n, logic [31:0] exp, string name);
        int port;
        port = (lane == 0) ? 0 : 1;
        for (int i = 0; i < n; i++) begin
            chk($sformatf("%s[%0d]", name, i),
                {3'b000, data[lane]}, {3'b000, exp[i]});
            pulse(port);
        end
    endtask

    initial begin
        vecs[0]  = '{2'd0, 32'h00000081, 12'h000, 0, 10, 32'h00000381, "std_p1"};
        vecs[1]  = '{2'd1, 32'h00800001, 12'h000, 0, 26, 32'h03108001, "fs_p1"};
        vecs[2]  = '{2'd1, 32'h00800001, 12'h000, 1, 26, 32'h03200000, "fs_p2"};
        vecs[3]  = '{2'd2, 32'h00000000, 12'h008, 3, 8,  32'h000000F1, "pp_d4"};
        vecs[4]  = '{2'd2, 32'h00000000, 12'h008, 2, 10, 32'h00000300, "pp_d3"};
        vecs[5]  = '{2'd3, 32'h0000005A, 12'h000, 0, 10, 32'h0000035A, "mode3"};
        vecs[6]  = '{2'd0, 32'h0000C300, 12'h000, 1, 10, 32'h000003C3, "std_p2"};
        vecs[7]  = '{2'd2, 32'h00000F00, 12'h000, 1, 10, 32'h0000030F, "pp_sr2"};
        vecs[8]  = '{2'd0, 32'h00000000, 12'hFFF, 3, 4,  32'h00000000, "std_d4"};
        vecs[9]  = '{2'd2, 32'h00000000, 12'hFFF, 2, 10, 32'h000003FF, "pp_d3f"};
        vecs[10] = '{2'd2, 32'h00000000, 12'hFFF, 3, 10, 32'h000003FF, "pp_d4f"};
        vecs[11] = '{2'd1, 32'hA5000000, 12'h000, 1, 26, 32'h0320A500, "fs_pad3"};

        reset_n  = 1'b0;
        mode     = 2'd0;
        pads     = 32'h0;
        powerpad = 12'h0;
        strobe   = 1'b0;
        jclk     = 2'b00;
`ifdef JOYPAD_TURBO_EN
        turbo    = 8'h00;
`endif
        tick();
        tick();
        chk("reset_state", data, 4'b0000);
        reset_n = 1'b1;
        tick();
        chk("idle_after_reset", data, 4'b0000);

        for (int v = 0; v < 12; v++) begin
            mode     = vecs[v].mode;
            pads     = vecs[v].pads;
            powerpad = vecs[v].pp;
            load();
            reads(vecs[v].lane, vecs[v].n, vecs[v].exp, vecs[v].name);
        end

        // strobe held high with falling edges: load wins every cycle
        mode = 2'd0;
        pads = 32'h00000001;
        jclk[0] = 1'b1;
        tick();
        strobe = 1'b1;
        for (int c = 0; c < 5; c++) begin
            jclk[0] = (c % 2 == 0) ? 1'b0 : 1'b1;
            tick();
            chk($sformatf("strobe_hold[%0d]", c), {3'b0, data[0]}, 4'd1);
        end
        strobe = 1'b0;
        tick();
        chk("strobe_rel_bit0", {3'b0, data[0]}, 4'd1);
        pulse(0);
        chk("strobe_rel_bit1", {3'b0, data[0]}, 4'd0);

        // mode change after load is ignored until the next strobe
        mode = 2'd0;
        pads = 32'h00000002;
        load();
        mode = 2'd1;
        reads(0, 10, 32'h00000302, "mode_chg");

        // reset in the middle of a Four Score read
        mode = 2'd1;
        pads = 32'h00800001;
        load();
        for (int i = 0; i < 3; i++) begin
            pulse(0);
            pulse(1);
        end
        reset_n = 1'b0;
        tick();
        chk("mid_reset", data, 4'b0000);
        reset_n = 1'b1;
        tick();
        chk("post_reset_idle", data, 4'b0000);
        load();
        chk("restart_bit0", {3'b0, data[0]}, 4'd1);
        pulse(0);
        chk("restart_bit1", {3'b0, data[0]}, 4'd0);

`ifdef JOYPAD_TURBO_EN
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        mode  = 2'd0;
        pads  = 32'h0;
        turbo = 8'h01;
        tick();
        for (int f = 0; f < 12; f++) begin
            load();
            chk($sformatf("turbo[%0d]", f), {3'b0, data[0]},
                {3'b0, 1'((f / 4) % 2)});
        end
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
